uart_alu_interface: RTL and testbench
=====================================

# uart_alu_interface

Sequencer between `rx_uart` and `tx_uart` in the UART–ALU path of `top`. It collects three received bytes in order: operand A, operand B, opcode. It holds them on registered ALU inputs, captures the combinational ALU result, and launches a single-byte transmission through `tx_uart`. It then waits for transmit completion before accepting the next frame.

## Interface
Parameters:
- `NB_DATA`, 8, byte and operand width
- `NB_OP`, 6, opcode width (low bits of the opcode byte)

Ports:
- `i_clock` in 1: system clock, same clock as `baudrate_generator`, `rx_uart` and `tx_uart`
- `i_reset` in 1: synchronous, active-high reset
- `i_rx_data` in NB_DATA: received byte from `rx_uart`
- `i_rx_done_tick` in 1: one-cycle strobe; `i_rx_data` is valid in that cycle
- `i_alu_result` in NB_DATA: combinational ALU output
- `i_tx_done_tick` in 1: one-cycle strobe from `tx_uart` at end of stop bit
- `o_alu_a` out NB_DATA: operand A register
- `o_alu_b` out NB_DATA: operand B register
- `o_alu_op` out NB_OP: opcode register
- `o_tx_data` out NB_DATA: byte to transmit
- `o_tx_start` out 1: one-cycle transmit request
- `o_error` out 1: one-cycle invalid-opcode strobe (see Configuration)

## Operation
- FSM states:
  - `WAIT_A`: reset state
  - `WAIT_B`
  - `WAIT_OP`
  - `SEND`
  - `WAIT_TX`
- Transitions:
  - `WAIT_A`: on `i_rx_done_tick`, `o_alu_a <= i_rx_data`, then go to `WAIT_B`.
  - `WAIT_B`: on `i_rx_done_tick`, `o_alu_b <= i_rx_data`, then go to `WAIT_OP`.
  - `WAIT_OP`: on `i_rx_done_tick`, `o_alu_op <= i_rx_data[NB_OP-1:0]`, then go to `SEND`. Upper bits `[NB_DATA-1:NB_OP]` are discarded.
  - `SEND`: unconditional, one cycle. `o_tx_data <= i_alu_result`, `o_tx_start <= 1`, then go to `WAIT_TX`.
  - `WAIT_TX`: on `i_tx_done_tick`, go to `WAIT_A`.
- `i_rx_done_tick` in `SEND` or `WAIT_TX` is ignored and the byte is dropped.
- A simultaneous `i_rx_done_tick` and `i_tx_done_tick` in `WAIT_TX`: go to `WAIT_A`; the rx byte is dropped.
- `i_tx_done_tick` in any state other than `WAIT_TX` is ignored.
- Operand and opcode registers hold their values until overwritten. They are not cleared between frames.
- `o_tx_data` holds its value until the next `SEND`.
- Reset, including mid-frame or mid-transmission: the state returns to `WAIT_A` and every output register clears to 0 in the cycle after the reset edge. Any partial frame is discarded.
- No arithmetic is performed in this block. Widths pass through unchanged.

## Timing
- Reset values: `o_alu_a`=0, `o_alu_b`=0, `o_alu_op`=0, `o_tx_data`=0, `o_tx_start`=0, `o_error`=0.
- Opcode strobe at edge N: `o_alu_op` is valid after edge N.
- Edge N+1 (state `SEND`): `i_alu_result` is sampled. The ALU therefore has one full cycle of combinational settling.
- After edge N+1: `o_tx_start`=1 for exactly one cycle, and `o_tx_data` is valid in the same cycle.
- Latency from the opcode strobe to the `o_tx_start` assertion is 2 cycles.
- The next frame's operand A is accepted no earlier than the cycle after `i_tx_done_tick`.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro `UART_ALU_OPCODE_CHECK_EN`.
- Defined: in `WAIT_OP`, the opcode byte is checked against the valid set: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010. Bits `[NB_DATA-1:NB_OP]` must also be zero.
  - Valid opcode: normal path.
  - Invalid opcode: `o_alu_op` is not updated, `o_error` pulses for one cycle (the cycle after the strobe), the state returns to `WAIT_A`, and no `o_tx_start` is issued.
- Undefined: every opcode byte is accepted, and `o_error` is tied to 0.

## Test plan
- Bytes 85, 1, 32 (ADD), with the ALU model returning A+B → `o_alu_a`=85, `o_alu_b`=1, `o_alu_op`=6'b100000. `o_tx_start` pulses once, 2 cycles after the third strobe, with `o_tx_data`=86. The state returns to `WAIT_A` after `i_tx_done_tick`.
- Bytes 5, 7, 34 (SUB) → `o_tx_data`=8'hFE with a single `o_tx_start`. A fourth byte sent during `WAIT_TX` leaves `o_alu_a` at 5.
- With the macro defined, bytes 3, 4, 8'h3F → `o_error` single pulse, no `o_tx_start`, `o_alu_op` unchanged. The next frame 2, 2, 32 yields `o_tx_data`=4.
- With the macro undefined, the same 3, 4, 8'h3F → `o_alu_op`=6'h3F, `o_error` stays 0, `o_tx_start` pulses.
- Reset asserted after A=9 and B=9, then released; bytes 1, 2, 32 → `o_tx_data`=3. The first post-reset byte is treated as A.
- `i_tx_done_tick` and `i_rx_done_tick` applied together in `WAIT_TX` → state `WAIT_A`, the byte is dropped, and `o_alu_a` is unchanged.

Source files
------------

// File: rtl/uart_alu_interface.sv
// Sequencer between rx_uart and tx_uart: collects A, B, opcode, launches one result byte, waits for tx completion.
// Optional opcode validation enabled by defining UART_ALU_OPCODE_CHECK_EN.
module uart_alu_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done_tick,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_error
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t             r_state, w_state_next;
    logic [NB_DATA-1:0] r_alu_a, w_alu_a_next;
    logic [NB_DATA-1:0] r_alu_b, w_alu_b_next;
    logic [NB_OP-1:0]   r_alu_op, w_alu_op_next;
    logic [NB_DATA-1:0] r_tx_data, w_tx_data_next;
    logic               r_tx_start, w_tx_start_next;
    logic               r_error, w_error_next;
    logic               w_op_valid;

`ifdef UART_ALU_OPCODE_CHECK_EN
    // Only the eight supported ALU functions are accepted, with the spare upper bits clear.
    always_comb begin
        w_op_valid = 1'b0;
        if (i_rx_data[NB_DATA-1:NB_OP] == '0) begin
            case (i_rx_data[NB_OP-1:0])
                NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
                NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b100111),
                NB_OP'(6'b000011), NB_OP'(6'b000010): w_op_valid = 1'b1;
                default:                               w_op_valid = 1'b0;
            endcase
        end
    end
`else
    assign w_op_valid = 1'b1;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= WAIT_A;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_alu_a    <= w_alu_a_next;
            r_alu_b    <= w_alu_b_next;
            r_alu_op   <= w_alu_op_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_start <= w_tx_start_next;
            r_error    <= w_error_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_alu_a_next    = r_alu_a;
        w_alu_b_next    = r_alu_b;
        w_alu_op_next   = r_alu_op;
        w_tx_data_next  = r_tx_data;
        w_tx_start_next = 1'b0;
        w_error_next    = 1'b0;
        case (r_state)
            WAIT_A: if (i_rx_done_tick) begin
                w_alu_a_next = i_rx_data;
                w_state_next = WAIT_B;
            end
            WAIT_B: if (i_rx_done_tick) begin
                w_alu_b_next = i_rx_data;
                w_state_next = WAIT_OP;
            end
            WAIT_OP: if (i_rx_done_tick) begin
                if (w_op_valid) begin
                    w_alu_op_next = i_rx_data[NB_OP-1:0];
                    w_state_next  = SEND;
                end else begin
                    w_error_next  = 1'b1;
                    w_state_next  = WAIT_A;
                end
            end
            // The opcode register has been stable for a full cycle, so the ALU output has settled.
            SEND: begin
                w_tx_data_next  = i_alu_result;
                w_tx_start_next = 1'b1;
                w_state_next    = WAIT_TX;
            end
            WAIT_TX: if (i_tx_done_tick) w_state_next = WAIT_A;
            default: w_state_next = WAIT_A;
        endcase
    end

    assign o_alu_a    = r_alu_a;
    assign o_alu_b    = r_alu_b;
    assign o_alu_op   = r_alu_op;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_error    = r_error;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface: directed frames from the test plan plus random frames.
// Expectations follow UART_ALU_OPCODE_CHECK_EN the same way as the design.
module tb_uart_alu_interface;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic [7:0] i_rx_data;
    logic       i_rx_done_tick;
    logic [7:0] i_alu_result;
    logic       i_tx_done_tick;
    logic [7:0] o_alu_a, o_alu_b, o_tx_data;
    logic [5:0] o_alu_op;
    logic       o_tx_start, o_error;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state of the frame registers
    logic [7:0] m_a, m_b, m_tx;
    logic [5:0] m_op;

    always #5 i_clock = ~i_clock;

    uart_alu_interface #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_rx_data      (i_rx_data),
        .i_rx_done_tick (i_rx_done_tick),
        .i_alu_result   (i_alu_result),
        .i_tx_done_tick (i_tx_done_tick),
        .o_alu_a        (o_alu_a),
        .o_alu_b        (o_alu_b),
        .o_alu_op       (o_alu_op),
        .o_tx_data      (o_tx_data),
        .o_tx_start     (o_tx_start),
        .o_error        (o_error)
    );

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b100111: return ~(a | b);
            6'b000011: return 8'($signed(a) >>> b);
            6'b000010: return a >> b;
            default:   return 8'h5A ^ a;
        endcase
    endfunction

    // Combinational ALU stand-in fed from the registered operands
    assign i_alu_result = alu(o_alu_a, o_alu_b, o_alu_op);

    function automatic bit accepted(input logic [7:0] opb);
`ifdef UART_ALU_OPCODE_CHECK_EN
        if (opb[7:6] != 2'b00) return 1'b0;
        return opb[5:0] inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b100110, 6'b100111, 6'b000011, 6'b000010};
`else
        return (opb == opb);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clock);
        i_rx_data      = b;
        i_rx_done_tick = 1'b1;
        @(negedge i_clock);
        i_rx_done_tick = 1'b0;
    endtask

    task automatic pulse_tx_done(input bit with_rx, input logic [7:0] b);
        @(negedge i_clock);
        i_tx_done_tick = 1'b1;
        i_rx_done_tick = with_rx;
        i_rx_data      = b;
        @(negedge i_clock);
        i_tx_done_tick = 1'b0;
        i_rx_done_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        chk("rst_a",     32'(o_alu_a),    0);
        chk("rst_b",     32'(o_alu_b),    0);
        chk("rst_op",    32'(o_alu_op),   0);
        chk("rst_tx",    32'(o_tx_data),  0);
        chk("rst_start", 32'(o_tx_start), 0);
        chk("rst_err",   32'(o_error),    0);
        i_reset = 1'b0;
        m_a = '0; m_b = '0; m_op = '0; m_tx = '0;
    endtask

    // mode 0: plain tx_done; 1: stray byte during WAIT_TX; 2: byte coincident with tx_done
    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input int mode, input int gap);
        send_byte(a);
        m_a = a;
        chk("a_load", 32'(o_alu_a), 32'(a));
        send_byte(b);
        m_b = b;
        chk("b_load", 32'(o_alu_b), 32'(b));
        send_byte(opb);
        if (!accepted(opb)) begin
            chk("err_pulse", 32'(o_error),    1);
            chk("op_kept",   32'(o_alu_op),   32'(m_op));
            chk("no_start0", 32'(o_tx_start), 0);
            @(negedge i_clock);
            chk("err_once",  32'(o_error),    0);
            chk("no_start1", 32'(o_tx_start), 0);
            chk("tx_kept",   32'(o_tx_data),  32'(m_tx));
            return;
        end
        m_op = opb[5:0];
        m_tx = alu(a, b, opb[5:0]);
        chk("op_load",   32'(o_alu_op),   32'(m_op));
        chk("no_err",    32'(o_error),    0);
        chk("start_lat", 32'(o_tx_start), 0);
        @(negedge i_clock);
        chk("start",     32'(o_tx_start), 1);
        chk("tx_data",   32'(o_tx_data),  32'(m_tx));
        @(negedge i_clock);
        chk("start_end", 32'(o_tx_start), 0);
        repeat (gap) @(negedge i_clock);
        if (mode == 1) begin
            send_byte(~a);
            chk("drop_wtx", 32'(o_alu_a), 32'(m_a));
        end
        pulse_tx_done(mode == 2, a ^ 8'h33);
        chk("drop_sim",  32'(o_alu_a),    32'(m_a));
        chk("tx_hold",   32'(o_tx_data),  32'(m_tx));
        chk("one_start", 32'(o_tx_start), 0);
    endtask

    initial begin
        logic [7:0] ops [8];
        logic [7:0] ra, rb, rop;
        ops = '{8'd32, 8'd34, 8'd36, 8'd37, 8'd38, 8'd39, 8'd3, 8'd2};
        i_reset = 1'b1; i_rx_data = '0; i_rx_done_tick = 1'b0; i_tx_done_tick = 1'b0;
        repeat (2) @(negedge i_clock);
        do_reset();

        // Stray tx_done outside WAIT_TX must not disturb a frame
        pulse_tx_done(1'b0, 8'h00);
        frame(8'd85, 8'd1, 8'd32, 0, 3);
        chk("add_res", 32'(o_tx_data), 86);
        frame(8'd5, 8'd7, 8'd34, 1, 2);
        chk("sub_res", 32'(o_tx_data), 32'h0FE);
        chk("sub_a",   32'(o_alu_a),   5);

        frame(8'd3, 8'd4, 8'h3F, 0, 1);
`ifdef UART_ALU_OPCODE_CHECK_EN
        chk("inv_op",  32'(o_alu_op), 34);
`else
        chk("inv_op",  32'(o_alu_op), 32'h3F);
`endif
        frame(8'd2, 8'd2, 8'd32, 0, 1);
        chk("add4",    32'(o_tx_data), 4);

        // Reset in the middle of a frame
        send_byte(8'd9);
        send_byte(8'd9);
        chk("mid_b", 32'(o_alu_b), 9);
        do_reset();
        frame(8'd1, 8'd2, 8'd32, 2, 4);
        chk("post_rst", 32'(o_tx_data), 3);

        for (int i = 0; i < 24; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, 7)];
            frame(ra, rb, rop, int'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
            chk("rnd_b", 32'(o_alu_b), 32'(m_b));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
